rf_tx_burst_sched: RTL
======================

// Module: rf_tx_burst_sched
// PURPOSE
//  Burst scheduler between two RF TX sample sources (src0 = test-pattern generator, src1 = baseband).
//  Round-robin arbitration grants one source per burst. Samples are pulled at a fixed strobe cadence
//  and driven onto the 2-antenna 12-bit IQ RF TX interface (O_RF_txXEn plus tx0/tx1 Re/Im).
//  Sits between the sample sources and the RF TX sink.
// PARAMETERS
//  STRB_DIV  4   clocks per sample strobe (>=2)
//  LEN_W     16  burst-length width, in samples
//  GAP_CYC   8   idle clocks after each burst, grant low (0 = no gap)
//  CNT_W     16  underrun counter width
// PORTS
//  I_clk          in   1      clock
//  I_rst_n        in   1      reset, asynchronous, active-low
//  I_enable       in   1      scheduler enable
//  I_tReady       in   1      RF sink ready, level; low = pause
//  I_req          in   2      burst request per source
//  I_len0/I_len1  in   LEN_W  burst length per source, sampled at grant
//  I_vld          in   2      sample available per source
//  I_s0Data       in   48     src0 sample {tx1Re,tx1Im,tx0Re,tx0Im}
//  I_s1Data       in   48     src1 sample, same packing
//  O_gnt          out  2      one-hot grant, high for IDLE->ARB..BURST end
//  O_rd           out  2      one-cycle sample pop to granted source
//  O_busy         out  1      state != IDLE
//  O_RF_txXEn     out  1      sample strobe
//  O_RF_tx0Im/tx0Re/tx1Im/tx1Re  out 12 each  IQ outputs
//  O_underrun_cnt out  CNT_W  only with RF_TX_UNDERRUN_CNT_EN
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; RR pointer set so src0 wins the first tie.
//  FSM IDLE->ARB: I_enable & any eligible req (eligible = I_req[i] & len_i!=0).
//  ARB (1 clk): pick eligible source; on a tie pick the one not served last; latch len; set O_gnt.
//  ARB->BURST next clk; divider cleared to 0.
//  BURST: divider counts 0..STRB_DIV-1 only while I_tReady=1; frozen (phase kept) while low.
//  Tick = divider==STRB_DIV-1 & I_tReady.
//   On tick, if I_vld[g]: O_rd[g]=1 that same clk (comb); sample registered.
//   Strobe: O_RF_txXEn=1 for exactly 1 clk at tick+1, with the new data.
//  Data outputs hold between strobes; O_RF_txXEn=0 elsewhere.
//  Underrun (tick & !I_vld[g]): no O_rd; all-zero sample emitted with strobe; counts as a sample.
//  Burst ends at the tick of sample #len -> GAP (GAP_CYC=0: -> IDLE). O_gnt drops the next clk.
//  GAP: O_gnt=0, count GAP_CYC clks -> IDLE.
//  I_req deassert mid-burst: ignored, burst runs to len (req sampled only in ARB).
//  I_enable low mid-burst: current burst completes; no new ARB.
//  I_rst_n low mid-burst: immediate return to reset values; no partial state is kept.
//  Widths: sample counter LEN_W, compare == latched len; no wrap possible.
// CONFIGURATION
//  RF_TX_UNDERRUN_CNT_EN defined: O_underrun_cnt +1 per underrun tick; saturates at 2^CNT_W-1;
//  cleared only by reset.
//  Undefined: no port, no counter; underrun still emits a zero sample.
// STRUCTURE
//  Package rf_tx_pkg: state enum {IDLE,ARB,BURST,GAP}; IQ_W=12; SMP_W=48; field offsets of the sample packing.
//  Sub-module rf_tx_strobe_div: freezable modulo-STRB_DIV counter producing tick.
// TESTING
//  1 I_rst_n=0 with random inputs -> all outputs 0, O_gnt=00; src0 granted first after release.
//  2 src0 req, len0=3, vld=1, STRB_DIV=4:
//    O_gnt=01; 3 O_rd[0] pulses 4 clks apart; 3 strobes each 1 clk later carrying I_s0Data;
//    then O_gnt=00 for 8 clks.
//  3 Both req held, len0=len1=2: grants 01,10,01,10 with 8-clk gaps; 2 strobes per burst.
//  4 I_tReady low 5 clks mid-burst, len=4:
//    no strobes while low; next strobe at the same divider phase; total strobes=4.
//  5 I_vld[g]=0 at 2nd tick, len=3: that strobe carries 0s and no O_rd; burst still 3 strobes;
//    O_underrun_cnt=1 (macro on); with CNT_W=2 and 5 underruns, saturates at 3.
//  6 len1=0 with req1=1 and req0=1: only src0 granted.
//    I_enable dropped mid-burst: burst finishes, then IDLE.

Source files
------------

// File: rtl/rf_tx_pkg.sv
// Shared types and constants for the RF TX burst scheduler.
//   state_t   : scheduler FSM states
//   IQ_W      : width of one I or Q component
//   SMP_W     : width of one packed 2-antenna sample {tx1Re,tx1Im,tx0Re,tx0Im}
//   *_LSB     : bit offsets of each component inside a packed sample
//   iq_field  : extracts one component from a packed sample
package rf_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int IQ_W  = 12;
    localparam int SMP_W = 48;

    localparam int TX0IM_LSB = 0;
    localparam int TX0RE_LSB = 12;
    localparam int TX1IM_LSB = 24;
    localparam int TX1RE_LSB = 36;

    function automatic logic [IQ_W-1:0] iq_field(input logic [SMP_W-1:0] smp, input int lsb);
        return smp[lsb +: IQ_W];
    endfunction

endpackage

// File: rtl/rf_tx_strobe_div.sv
// Freezable modulo-DIV counter that produces the sample tick.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear to phase 0 (has priority over i_en)
//   i_en    : advance the phase; when low the phase is held
//   o_tick  : high while the phase is DIV-1 and i_en is high
module rf_tx_strobe_div #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int            W    = $clog2(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    // Phase counter: cleared, advanced with wrap, or frozen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {W{1'b0}};
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? {W{1'b0}} : r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tick = i_en & (r_cnt == LAST);

endmodule

// File: rtl/rf_tx_burst_sched.sv
// Round-robin burst scheduler between two RF TX sample sources
// (src0 = test pattern, src1 = baseband) feeding a 2-antenna 12-bit IQ sink.
// Optional feature macro: RF_TX_UNDERRUN_CNT_EN adds O_underrun_cnt.
//   I_clk, I_rst_n        : clock, asynchronous active-low reset
//   I_enable              : scheduler enable (checked only when idle)
//   I_tReady              : sink ready; low freezes the strobe phase
//   I_req[1:0]            : burst request per source (sampled only in ARB)
//   I_len0, I_len1        : burst length per source, latched at grant
//   I_vld[1:0]            : sample available per source
//   I_s0Data, I_s1Data    : packed samples {tx1Re,tx1Im,tx0Re,tx0Im}
//   O_gnt[1:0]            : one-hot grant for the running burst
//   O_rd[1:0]             : same-cycle pop to the granted source on a tick
//   O_busy                : scheduler not idle
//   O_RF_txXEn            : one-clock strobe marking new IQ data
//   O_RF_tx{0,1}{Re,Im}   : IQ outputs, held between strobes
//   O_underrun_cnt        : saturating underrun count (macro only)
module rf_tx_burst_sched
    import rf_tx_pkg::*;
#(
    parameter int STRB_DIV = 4,
    parameter int LEN_W    = 16,
    parameter int GAP_CYC  = 8,
    parameter int CNT_W    = 16
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_enable,
    input  logic             I_tReady,
    input  logic [1:0]       I_req,
    input  logic [LEN_W-1:0] I_len0,
    input  logic [LEN_W-1:0] I_len1,
    input  logic [1:0]       I_vld,
    input  logic [SMP_W-1:0] I_s0Data,
    input  logic [SMP_W-1:0] I_s1Data,
    output logic [1:0]       O_gnt,
    output logic [1:0]       O_rd,
    output logic             O_busy,
    output logic             O_RF_txXEn,
    output logic [IQ_W-1:0]  O_RF_tx0Im,
    output logic [IQ_W-1:0]  O_RF_tx0Re,
    output logic [IQ_W-1:0]  O_RF_tx1Im,
    output logic [IQ_W-1:0]  O_RF_tx1Re
`ifdef RF_TX_UNDERRUN_CNT_EN
    ,
    output logic [CNT_W-1:0] O_underrun_cnt
`endif
);

    localparam bit                NO_GAP   = (GAP_CYC == 0);
    localparam int                GAP_W    = $clog2(GAP_CYC + 2);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_gnt;
    logic               r_last;      // 1 = src1 served last, so src0 wins the next tie
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_smp_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_busy;
    logic               r_txen;
    logic [SMP_W-1:0]   r_data;

    logic [1:0]         w_elig;
    logic               w_pick1;
    logic               w_tick;
    logic               w_vld_g;
    logic               w_last_smp;
    logic [SMP_W-1:0]   w_smp_sel;

    // A zero length makes a request ineligible.
    assign w_elig     = I_req & {(I_len1 != {LEN_W{1'b0}}), (I_len0 != {LEN_W{1'b0}})};
    assign w_pick1    = w_elig[1] & (~w_elig[0] | ~r_last);
    assign w_vld_g    = |(I_vld & r_gnt);
    assign w_last_smp = ((r_smp_cnt + LEN_W'(1)) == r_len);
    assign w_smp_sel  = r_gnt[1] ? I_s1Data : I_s0Data;

    rf_tx_strobe_div #(
        .DIV (STRB_DIV)
    ) u_div (
        .i_clk   (I_clk),
        .i_rst_n (I_rst_n),
        .i_clr   (r_state != BURST),
        .i_en    ((r_state == BURST) & I_tReady),
        .o_tick  (w_tick)
    );

    // FSM state register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (I_enable && (|w_elig)) w_next = ARB;
                else                       w_next = IDLE;
            end
            ARB: begin
                if (|w_elig) w_next = BURST;
                else         w_next = IDLE;
            end
            BURST: begin
                if (w_tick && w_last_smp) w_next = NO_GAP ? IDLE : GAP;
                else                      w_next = BURST;
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next = IDLE;
                else                       w_next = GAP;
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM output logic: the pop must land in the tick cycle itself.
    always_comb begin
        O_rd = 2'b00;
        if ((r_state == BURST) && w_tick && w_vld_g) begin
            O_rd = r_gnt;
        end else begin
            O_rd = 2'b00;
        end
    end

    // Grant, round-robin pointer, latched length and sample counter.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_gnt     <= 2'b00;
            r_last    <= 1'b1;
            r_len     <= {LEN_W{1'b0}};
            r_smp_cnt <= {LEN_W{1'b0}};
        end else begin
            case (r_state)
                ARB: begin
                    r_smp_cnt <= {LEN_W{1'b0}};
                    if (|w_elig) begin
                        r_gnt  <= w_pick1 ? 2'b10 : 2'b01;
                        r_len  <= w_pick1 ? I_len1 : I_len0;
                        r_last <= w_pick1;
                    end else begin
                        r_gnt  <= 2'b00;
                    end
                end
                BURST: begin
                    if (w_tick) begin
                        r_smp_cnt <= r_smp_cnt + LEN_W'(1);
                        if (w_last_smp) r_gnt <= 2'b00;
                        else            r_gnt <= r_gnt;
                    end else begin
                        r_smp_cnt <= r_smp_cnt;
                    end
                end
                default: begin
                    r_gnt <= 2'b00;
                end
            endcase
        end
    end

    // Post-burst gap timer; idles at zero outside GAP.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_gap_cnt <= {GAP_W{1'b0}};
        end else if (r_state == GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= {GAP_W{1'b0}};
        end
    end

    // Registered busy flag, strobe and IQ sample (zero sample on underrun).
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_busy <= 1'b0;
            r_txen <= 1'b0;
            r_data <= {SMP_W{1'b0}};
        end else begin
            r_busy <= (w_next != IDLE);
            r_txen <= w_tick;
            if (w_tick) begin
                r_data <= w_vld_g ? w_smp_sel : {SMP_W{1'b0}};
            end else begin
                r_data <= r_data;
            end
        end
    end

`ifdef RF_TX_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] r_urun_cnt;

    // Saturating count of ticks that found the granted source empty.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_urun_cnt <= {CNT_W{1'b0}};
        end else if (w_tick && !w_vld_g && (r_urun_cnt != {CNT_W{1'b1}})) begin
            r_urun_cnt <= r_urun_cnt + CNT_W'(1);
        end else begin
            r_urun_cnt <= r_urun_cnt;
        end
    end

    assign O_underrun_cnt = r_urun_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = {CNT_W{1'b0}};
`endif

    assign O_gnt      = r_gnt;
    assign O_busy     = r_busy;
    assign O_RF_txXEn = r_txen;
    assign O_RF_tx0Im = iq_field(r_data, TX0IM_LSB);
    assign O_RF_tx0Re = iq_field(r_data, TX0RE_LSB);
    assign O_RF_tx1Im = iq_field(r_data, TX1IM_LSB);
    assign O_RF_tx1Re = iq_field(r_data, TX1RE_LSB);

endmodule
